// File: rtl/morse_pkg.sv
// Morse digit receiver: shared timing defaults, FSM states and digit code table.
// The digit encoder is meant to take its table from here as well.
package morse_pkg;

  localparam int unsigned CLK_HZ_DEF = 100_000_000;

  // A mark shorter than this is treated as line noise.
  function automatic int unsigned glitch_len(input int unsigned dot);
    return dot / 4;
  endfunction

  // Midpoint between dot and dash lengths.
  function automatic int unsigned dash_thresh(input int unsigned dot,
                                              input int unsigned dash);
    return (dot + dash) / 2;
  endfunction

  // A mark this long means the line is stuck high.
  function automatic int unsigned max_mark(input int unsigned dash);
    return 2 * dash;
  endfunction

  // Silence this long closes the current digit.
  function automatic int unsigned end_gap(input int unsigned pause);
    return pause / 2;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SPACE,
    EMIT,
    WAIT_LOW
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] digit;
  } lookup_t;

  // Digit to 5-symbol pattern, MSB sent first, 1 = dash.
  function automatic logic [4:0] digit_pattern(input logic [3:0] d);
    logic [4:0] p;
    p = 5'b00000;
    case (d)
      4'd0:    p = 5'b11111;
      4'd1:    p = 5'b01111;
      4'd2:    p = 5'b00111;
      4'd3:    p = 5'b00011;
      4'd4:    p = 5'b00001;
      4'd5:    p = 5'b00000;
      4'd6:    p = 5'b10000;
      4'd7:    p = 5'b11000;
      4'd8:    p = 5'b11100;
      4'd9:    p = 5'b11110;
      default: p = 5'b00000;
    endcase
    return p;
  endfunction

  // Pattern back to digit; hit is clear for patterns outside the table.
  function automatic lookup_t pattern_digit(input logic [4:0] p);
    lookup_t r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (digit_pattern(4'(i)) == p) begin
        r.hit   = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_sync.sv
// Two-flop synchroniser for the asynchronous Morse line,
// with rise/fall strobes taken on the synchronised level.
module morse_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic s_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resynchronise the line and keep one cycle of history for edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign s_out = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/morse_code_decoder.sv
// Morse digit receiver: times marks and spaces on the line, collects
// five dot/dash symbols and strobes out the decoded digit 0-9.
module morse_code_decoder
  import morse_pkg::*;
#(
  parameter int unsigned CLK_HZ      = CLK_HZ_DEF,
  parameter int unsigned DOT_LEN     = CLK_HZ * 1,
  parameter int unsigned DASH_LEN    = CLK_HZ * 3,
  parameter int unsigned SYMBOL_GAP  = CLK_HZ / 2,
  parameter int unsigned DIGIT_PAUSE = CLK_HZ * 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       morse_in,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  output logic       decode_err,
  output logic [2:0] symbol_cnt,
  output logic       busy
);

  localparam logic [31:0] GLITCH_LEN  = glitch_len(DOT_LEN);
  localparam logic [31:0] DASH_THRESH = dash_thresh(DOT_LEN, DASH_LEN);
  localparam logic [31:0] MAX_MARK    = max_mark(DASH_LEN);
  localparam logic [31:0] END_GAP     = end_gap(DIGIT_PAUSE);

  // An intra-digit space must end well before the digit-close gap.
  if (SYMBOL_GAP >= end_gap(DIGIT_PAUSE)) begin : g_gap_chk
    $error("SYMBOL_GAP must be shorter than DIGIT_PAUSE/2");
  end

  logic        s_in;
  logic        rise;
  logic        fall;

  logic [31:0] timer_q;
  logic        tmr_clr;

  state_t      state_q;
  state_t      state_nxt;
  logic [4:0]  shift_q;
  logic [4:0]  shift_nxt;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_nxt;
  logic        ovf_q;
  logic        ovf_nxt;
  logic        busy_q;
  logic        busy_nxt;
  logic [3:0]  digit_q;
  logic [3:0]  digit_nxt;

  logic        valid;
  logic        err;
  logic        is_dash;
  lookup_t     lk;

  morse_sync u_sync (
    .clk   (clk),
    .rst   (rst),
    .d_in  (morse_in),
    .s_out (s_in),
    .rise  (rise),
    .fall  (fall)
  );

  // Mark/space timer: restarts on each line edge, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else if (tmr_clr) begin
      timer_q <= '0;
    end else if (timer_q != '1) begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // State and digit context registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      digit_q <= '0;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      cnt_q   <= cnt_nxt;
      ovf_q   <= ovf_nxt;
      busy_q  <= busy_nxt;
      digit_q <= digit_nxt;
    end
  end

  // Next-state, symbol classification and strobe generation.
  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    cnt_nxt   = cnt_q;
    ovf_nxt   = ovf_q;
    busy_nxt  = busy_q;
    digit_nxt = digit_q;
    valid     = 1'b0;
    err       = 1'b0;
    tmr_clr   = rise | fall;
    is_dash   = (timer_q >= DASH_THRESH);
    lk        = pattern_digit(shift_q);

    case (state_q)
      IDLE: begin
        if (s_in) begin
          state_nxt = MARK;
          tmr_clr   = 1'b1;
        end
      end

      MARK: begin
        if (fall) begin
          if (timer_q < GLITCH_LEN) begin
            state_nxt = (cnt_q != 3'd0) ? SPACE : IDLE;
          end else begin
            shift_nxt = {shift_q[3:0], is_dash};
            if (cnt_q == 3'd5) begin
              ovf_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt_q + 3'd1;
            end
            busy_nxt  = 1'b1;
            state_nxt = SPACE;
          end
        end else if (timer_q >= MAX_MARK) begin
          err       = 1'b1;
          shift_nxt = '0;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = WAIT_LOW;
        end
      end

      SPACE: begin
        // The digit-close gap takes priority over a simultaneous mark.
        if (timer_q == END_GAP) begin
          state_nxt = EMIT;
        end else if (rise) begin
          state_nxt = MARK;
        end
      end

      EMIT: begin
        if ((cnt_q == 3'd5) && !ovf_q && lk.hit) begin
          valid     = 1'b1;
          digit_nxt = lk.digit;
        end else begin
          err = 1'b1;
        end
        shift_nxt = '0;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end

      WAIT_LOW: begin
        if (!s_in) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign digit_valid = valid;
  assign decode_err  = err;
  assign digit_out   = valid ? lk.digit : digit_q;
  assign symbol_cnt  = cnt_q;
  assign busy        = busy_q;

endmodule

// File: doc/morse_code_decoder.md
Name: morse_code_decoder

Overview:
Receive-side counterpart of the on-board Morse digit encoder. It samples a single Morse line (encoder LED loopback or a key switch) and times each mark and space. Marks are classified as dot or dash, and the collected 5-symbol patterns are decoded into digits 0-9. Each decoded digit is presented with a one-cycle strobe to the display or digit-buffer logic.

Parameters:
CLK_HZ, 100_000_000, system clock frequency
DOT_LEN, CLK_HZ*1, nominal dot mark length in cycles
DASH_LEN, CLK_HZ*3, nominal dash mark length in cycles
SYMBOL_GAP, CLK_HZ/2, nominal intra-digit space in cycles
DIGIT_PAUSE, CLK_HZ*10, nominal inter-digit space in cycles
Derived constants, not overridable:
- GLITCH_LEN = DOT_LEN/4
- DASH_THRESH = (DOT_LEN+DASH_LEN)/2
- MAX_MARK = 2*DASH_LEN
- END_GAP = DIGIT_PAUSE/2

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
morse_in  in  1  asynchronous Morse line, 1 = mark
digit_out  out  4  last decoded digit, held until next strobe
digit_valid  out  1  one-cycle pulse, digit_out updated this cycle
decode_err  out  1  one-cycle pulse, malformed digit
symbol_cnt  out  3  symbols collected in current digit (0..5, saturating)
busy  out  1  high from first accepted mark until digit_valid/decode_err

Behaviour:
- Reset: every output is 0; state IDLE; timer 0; shift register 0; overflow flag 0; synchroniser flops 0.
- Input synchronisation: 2-flop synchroniser giving s_in; all timing uses s_in, adding 2 cycles of latency. Edges are detected on s_in versus its previous value.
- Timer: 32-bit, clears on every s_in edge, increments otherwise, saturates at all-ones.
- IDLE: waits for s_in=1, then goes to MARK with timer cleared.
- MARK, on s_in falling edge:
  - timer < GLITCH_LEN: mark discarded. Go to SPACE if symbol_cnt>0, else IDLE. Shift register unchanged.
  - GLITCH_LEN <= timer < DASH_THRESH: dot, shift in 0.
  - timer >= DASH_THRESH: dash, shift in 1.
  - After a dot or dash, symbol_cnt increments. If symbol_cnt was already 5, the overflow flag is set instead. Next state is SPACE.
- MARK, stuck line: if the timer reaches MAX_MARK while still in MARK, pulse decode_err, clear the digit context and go to WAIT_LOW. WAIT_LOW returns to IDLE on s_in=0.
- busy is raised on the first accepted (non-glitch) mark.
- SPACE:
  - s_in rising edge: go to MARK.
  - timer == END_GAP: go to EMIT.
- Shift register: 5 bits, MSB is the first symbol, shifted left with the new symbol in the LSB.
- Code table (1 = dash):
  - 0=11111, 1=01111, 2=00111, 3=00011, 4=00001
  - 5=00000, 6=10000, 7=11000, 8=11100, 9=11110
- EMIT, single cycle:
  - symbol_cnt==5, no overflow, pattern in table: digit_out <= digit, digit_valid=1.
  - Any other case: decode_err=1, digit_out unchanged.
  - Then clear symbol_cnt, shift register and overflow, drop busy, go to IDLE.
- Latency: the strobe comes END_GAP+3 cycles after the last falling edge of morse_in (2 sync + 1 EMIT).
- digit_valid and decode_err are mutually exclusive and never asserted in consecutive cycles.
- A mark arriving in the same cycle SPACE reaches END_GAP: the gap wins and EMIT happens. The mark is then accepted from IDLE on the following cycle.
- Reset mid-digit: all context is discarded immediately and no strobe is produced.

Decomposition:
- Package morse_pkg holds:
  - the timing defaults and derived-threshold functions
  - the state enum: IDLE, MARK, SPACE, EMIT, WAIT_LOW
  - the 10-entry code table as a function, digit to pattern plus inverse lookup with a hit flag
- The encoder is expected to move its table into morse_pkg later.
- One sub-module: morse_sync (2-flop synchroniser plus edge-detect outputs).

Test Plan:
Bench parameters: DOT_LEN=8, DASH_LEN=24, SYMBOL_GAP=4, DIGIT_PAUSE=80, giving GLITCH_LEN=2, DASH_THRESH=16, MAX_MARK=48, END_GAP=40.
- Digit 7 (24H,4L,24H,4L,8H,4L,8H,4L,8H then low) -> exactly one digit_valid, digit_out=7, 43 cycles after the last fall; busy low afterwards.
- Digits 3 then 0 separated by an 80-cycle low -> two strobes, values 3 then 0, no decode_err.
- Digit 5 with a 1-cycle high glitch inserted in the second space -> digit_out=5, symbol_cnt peaks at 5.
- Only 3 dots, then low -> decode_err pulse at END_GAP, digit_valid stays 0, digit_out keeps its prior value.
- 6 dots -> decode_err; the line held high for 60 cycles -> decode_err at timer 48, then no activity until the line returns low.
- rst asserted after 2 symbols of digit 9, then a full digit 4 -> only digit_out=4 is strobed.
